// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: ID/EX control-word mux
// select and the hazard FSM state encoding.
package controlmux;
  typedef enum logic {
    ctrl = 1'b0,
    zero = 1'b1
  } controlmux_sel_t;
endpackage

package rv32i_types;
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_STALL  = 2'd1,
    FLUSH_PEND = 2'd2
  } hazard_state_t;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that increments once per enabled cycle and sticks at all-ones.
module sat_counter #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [width-1:0] cnt_o
);
  logic [width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + width'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-stall freeze, taken-branch flush (deferred
// across stalls) and load-use bubble insertion, with saturating event counters.
module hazard_ctrl
  import rv32i_types::*;
  import controlmux::*;
#(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_br_taken_i,
  input  logic             imem_read_i,
  input  logic             imem_resp_i,
  input  logic             dmem_req_i,
  input  logic             dmem_resp_i,
  output logic             pc_load_o,
  output logic             if_id_load_o,
  output logic             id_ex_load_o,
  output logic             ex_mem_load_o,
  output logic             mem_wb_load_o,
  output logic             if_id_flush_o,
  output controlmux_sel_t  controlmux_sel_o,
  output logic [width-1:0] stall_cnt_o,
  output logic [width-1:0] flush_cnt_o,
  output logic [width-1:0] bubble_cnt_o
);
  hazard_state_t state_q, state_d;
  logic          pend_q, pend_d;
  logic          mem_wait, load_use;
  logic          stall_inc, flush_inc, bubble_inc;

  assign mem_wait = (imem_read_i && !imem_resp_i) || (dmem_req_i && !dmem_resp_i);
  assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));

  // Outputs are purely combinational from inputs and current state; a taken
  // branch seen while frozen is remembered in pend and replayed via FLUSH_PEND.
  always_comb begin
    pc_load_o        = 1'b1;
    if_id_load_o     = 1'b1;
    id_ex_load_o     = 1'b1;
    ex_mem_load_o    = 1'b1;
    mem_wb_load_o    = 1'b1;
    if_id_flush_o    = 1'b0;
    controlmux_sel_o = ctrl;
    state_d          = state_q;
    pend_d           = pend_q;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;
    bubble_inc       = 1'b0;

    if (!rst) begin
      if (mem_wait) begin
        pc_load_o     = 1'b0;
        if_id_load_o  = 1'b0;
        id_ex_load_o  = 1'b0;
        ex_mem_load_o = 1'b0;
        mem_wb_load_o = 1'b0;
        state_d       = MEM_STALL;
        pend_d        = pend_q || ex_br_taken_i;
        stall_inc     = 1'b1;
      end else begin
        unique case (state_q)
          MEM_STALL: begin
            state_d = pend_q ? FLUSH_PEND : RUN;
          end
          FLUSH_PEND: begin
            if_id_flush_o    = 1'b1;
            controlmux_sel_o = zero;
            pend_d           = 1'b0;
            flush_inc        = 1'b1;
            state_d          = RUN;
          end
          default: begin
            state_d = RUN;
            if (ex_br_taken_i) begin
              if_id_flush_o    = 1'b1;
              controlmux_sel_o = zero;
              pend_d           = 1'b0;
              flush_inc        = 1'b1;
            end else if (load_use) begin
              pc_load_o        = 1'b0;
              if_id_load_o     = 1'b0;
              controlmux_sel_o = zero;
              bubble_inc       = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  sat_counter #(.width(width)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.width(width)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

  sat_counter #(.width(width)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (bubble_inc),
    .cnt_o (bubble_cnt_o)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic, all checked
// against an event-level reference model; a 3-bit instance exercises saturation.
module tb_hazard_ctrl;
  import controlmux::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1, rs2, exrd;
  logic       uses2, memrd, br, iread, iresp, dreq, dresp;

  logic            pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, flush;
  controlmux_sel_t sel;
  logic [31:0]     sc, fc, bc;

  logic            s_pc_ld, s_ifid_ld, s_idex_ld, s_exmem_ld, s_memwb_ld, s_flush;
  controlmux_sel_t s_sel;
  logic [2:0]      s_sc, s_fc, s_bc;

  hazard_ctrl #(.width(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs2_i(uses2),
    .ex_rd_i(exrd), .ex_mem_read_i(memrd), .ex_br_taken_i(br),
    .imem_read_i(iread), .imem_resp_i(iresp),
    .dmem_req_i(dreq), .dmem_resp_i(dresp),
    .pc_load_o(pc_ld), .if_id_load_o(ifid_ld), .id_ex_load_o(idex_ld),
    .ex_mem_load_o(exmem_ld), .mem_wb_load_o(memwb_ld),
    .if_id_flush_o(flush), .controlmux_sel_o(sel),
    .stall_cnt_o(sc), .flush_cnt_o(fc), .bubble_cnt_o(bc)
  );

  hazard_ctrl #(.width(3)) dut_small (
    .clk(clk), .rst(rst),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs2_i(uses2),
    .ex_rd_i(exrd), .ex_mem_read_i(memrd), .ex_br_taken_i(br),
    .imem_read_i(iread), .imem_resp_i(iresp),
    .dmem_req_i(dreq), .dmem_resp_i(dresp),
    .pc_load_o(s_pc_ld), .if_id_load_o(s_ifid_ld), .id_ex_load_o(s_idex_ld),
    .ex_mem_load_o(s_exmem_ld), .mem_wb_load_o(s_memwb_ld),
    .if_id_flush_o(s_flush), .controlmux_sel_o(s_sel),
    .stall_cnt_o(s_sc), .flush_cnt_o(s_fc), .bubble_cnt_o(s_bc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: "frozen" = last cycle was a memory freeze; "owe" = a taken
  // branch was seen while frozen and its flush has not been issued yet.
  bit     m_frozen, m_owe;
  longint m_sc, m_fc, m_bc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] satv(input longint v, input longint maxv);
    return (v > maxv) ? 32'(maxv) : 32'(v);
  endfunction

  task automatic idle_inputs();
    rst = 0; rs1 = 0; rs2 = 0; exrd = 0; uses2 = 0; memrd = 0; br = 0;
    iread = 0; iresp = 0; dreq = 0; dresp = 0;
  endtask

  // One clock: inputs already driven; check outputs mid-cycle, advance model
  // across the edge, then check counters.
  task automatic cyc();
    bit mw, lu;
    bit e_pc, e_ifid, e_rest, e_flush, e_zero;
    bit n_frozen, n_owe;
    #2;
    mw = (iread && !iresp) || (dreq && !dresp);
    lu = memrd && exrd != 0 && (exrd == rs1 || (uses2 && exrd == rs2));
    e_pc = 1; e_ifid = 1; e_rest = 1; e_flush = 0; e_zero = 0;
    n_frozen = m_frozen; n_owe = m_owe;
    if (rst) begin
      n_frozen = 0; n_owe = 0;
    end else if (mw) begin
      e_pc = 0; e_ifid = 0; e_rest = 0;
      n_frozen = 1; n_owe = m_owe | br;
      m_sc++;
    end else if (m_frozen) begin
      n_frozen = 0;
    end else if (m_owe || br) begin
      e_flush = 1; e_zero = 1; n_owe = 0;
      m_fc++;
    end else if (lu) begin
      e_pc = 0; e_ifid = 0; e_zero = 1;
      m_bc++;
    end
    chk("pc_load", 32'(pc_ld), 32'(e_pc));
    chk("if_id_load", 32'(ifid_ld), 32'(e_ifid));
    chk("id_ex_load", 32'(idex_ld), 32'(e_rest));
    chk("ex_mem_load", 32'(exmem_ld), 32'(e_rest));
    chk("mem_wb_load", 32'(memwb_ld), 32'(e_rest));
    chk("if_id_flush", 32'(flush), 32'(e_flush));
    chk("controlmux_sel", 32'(sel == zero), 32'(e_zero));
    chk("small_pc_load", 32'(s_pc_ld), 32'(e_pc));
    chk("small_flush", 32'(s_flush), 32'(e_flush));
    @(posedge clk);
    #1;
    m_frozen = n_frozen; m_owe = n_owe;
    if (rst) begin m_sc = 0; m_fc = 0; m_bc = 0; end
    chk("stall_cnt", sc, satv(m_sc, 64'hFFFF_FFFF));
    chk("flush_cnt", fc, satv(m_fc, 64'hFFFF_FFFF));
    chk("bubble_cnt", bc, satv(m_bc, 64'hFFFF_FFFF));
    chk("small_stall_cnt", 32'(s_sc), satv(m_sc, 7));
    chk("small_flush_cnt", 32'(s_fc), satv(m_fc, 7));
    chk("small_bubble_cnt", 32'(s_bc), satv(m_bc, 7));
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  initial begin
    m_frozen = 0; m_owe = 0; m_sc = 0; m_fc = 0; m_bc = 0;
    idle_inputs();
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    chk("reset_stall_cnt", sc, 32'd0);
    cyc();

    // Load-use on rs1
    memrd = 1; exrd = 5; rs1 = 5;
    #2;
    chk("lu_pc_load", 32'(pc_ld), 32'd0);
    chk("lu_sel", 32'(sel == zero), 32'd1);
    cyc();
    chk("lu_bubble_cnt", bc, 32'd1);
    memrd = 0;
    cyc();

    // Load-use via rs2, and no hazard when rs2 is unused
    memrd = 1; exrd = 9; rs1 = 1; rs2 = 9; uses2 = 1;
    cyc();
    uses2 = 0;
    cyc();
    idle_inputs();

    // x0 never hazards
    memrd = 1; exrd = 0; rs1 = 0; rs2 = 0; uses2 = 1;
    #2;
    chk("x0_pc_load", 32'(pc_ld), 32'd1);
    cyc();
    idle_inputs();

    // dmem miss of 4 cycles, then response
    do_reset();
    dreq = 1; dresp = 0;
    repeat (4) cyc();
    dresp = 1;
    #2;
    chk("resp_cycle_load", 32'(mem_wb_load_o_all()), 32'd1);
    cyc();
    chk("miss_stall_cnt", sc, 32'd4);
    idle_inputs();
    cyc();

    // Taken branch in stall cycle 2, flush issued once after response
    do_reset();
    dreq = 1; dresp = 0;
    cyc();
    br = 1; cyc();
    br = 0; cyc(); cyc();
    dresp = 1; cyc();
    idle_inputs();
    #2;
    chk("pend_flush_issued", 32'(flush), 32'd1);
    cyc();
    chk("pend_flush_cnt", fc, 32'd1);
    cyc();

    // Branch coinciding with load-use: flush only
    memrd = 1; exrd = 3; rs1 = 3; br = 1;
    cyc();
    chk("br_lu_bubble_cnt", bc, 32'd0);
    idle_inputs();
    cyc();

    // Reset in mid-stall with a pending flush discards it
    iread = 1; iresp = 0; br = 1;
    cyc(); cyc();
    br = 0;
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_mid_flush_cnt", fc, 32'd0);
    iresp = 1;
    cyc();
    idle_inputs();
    cyc();
    #2;
    chk("rst_no_flush", 32'(flush), 32'd0);
    cyc();

    // Saturation of the 3-bit instance: 10 freeze cycles
    dreq = 1; dresp = 0;
    repeat (10) cyc();
    chk("small_stall_sat", 32'(s_sc), 32'd7);
    dresp = 1; cyc();
    idle_inputs();
    cyc();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      exrd  = 5'($urandom_range(0, 3));
      uses2 = 1'($urandom_range(0, 1));
      memrd = ($urandom_range(0, 2) == 0);
      br    = ($urandom_range(0, 5) == 0);
      iread = 1'($urandom_range(0, 1));
      iresp = ($urandom_range(0, 3) != 0);
      dreq  = ($urandom_range(0, 2) == 0);
      dresp = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  function automatic logic mem_wb_load_o_all();
    return pc_ld & ifid_ld & idex_ld & exmem_ld & memwb_ld;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter: width, 32, datapath and counter width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1_i  in  5  rs1 index of the instruction in ID.
- id_rs2_i  in  5  rs2 index of the instruction in ID.
- id_uses_rs2_i  in  1  ID instruction reads rs2 (op, store, branch).
- ex_rd_i  in  5  rd of the instruction in EX.
- ex_mem_read_i  in  1  EX instruction is a load.
- ex_br_taken_i  in  1  EX resolved a taken branch or jump.
- imem_read_i  in  1  IF fetch request outstanding.
- imem_resp_i  in  1  instruction memory response.
- dmem_req_i  in  1  MEM stage read or write outstanding.
- dmem_resp_i  in  1  data memory response.
- pc_load_o  out  1  PC register enable.
- if_id_load_o, id_ex_load_o, ex_mem_load_o, mem_wb_load_o  out  1 each  pipeline register enables.
- if_id_flush_o  out  1  load a NOP into IF/ID.
- controlmux_sel_o  out  controlmux::controlmux_sel_t  zero inserts a bubble into ID/EX; ctrl passes the decoded word.
- stall_cnt_o  out  width  cycles frozen by memory stalls.
- flush_cnt_o  out  width  taken-branch flushes applied.
- bubble_cnt_o  out  width  load-use bubbles inserted.

Function
REQ-003 SHALL implement an FSM with states RUN, MEM_STALL and FLUSH_PEND.
REQ-004 SHALL define mem_wait as (imem_read_i AND NOT imem_resp_i) OR (dmem_req_i AND NOT dmem_resp_i).
REQ-005 SHALL define load_use as ex_mem_read_i AND ex_rd_i != 0 AND (ex_rd_i == id_rs1_i OR (id_uses_rs2_i AND ex_rd_i == id_rs2_i)).
REQ-006 In RUN with no event, SHALL drive all load outputs to 1, if_id_flush_o to 0 and controlmux_sel_o to ctrl.
REQ-007 SHALL apply the event priority mem_wait > ex_br_taken_i > load_use, evaluated combinationally in the same cycle.
REQ-008 On mem_wait in any state, SHALL drive all load outputs to 0 and controlmux_sel_o to ctrl (full freeze), and SHALL enter or stay in MEM_STALL.
REQ-009 In MEM_STALL, if ex_br_taken_i is high in any stalled cycle, SHALL set pend_flush.
REQ-010 In MEM_STALL, when mem_wait deasserts, SHALL drive all loads to 1 in that same cycle and go to FLUSH_PEND if pend_flush is set, else to RUN.
REQ-011 On a taken branch in RUN, or on the single cycle spent in FLUSH_PEND, SHALL drive all loads to 1, if_id_flush_o to 1 and controlmux_sel_o to zero, squashing exactly 2 younger instructions.
REQ-012 SHALL clear pend_flush when the flush is applied, and FLUSH_PEND SHALL return to RUN unless mem_wait is high.
REQ-013 On load_use with no higher-priority event, SHALL drive pc_load_o and if_id_load_o to 0, the other loads to 1 and controlmux_sel_o to zero, for exactly 1 cycle.
- The inserted bubble has mem_read 0, so load_use self-clears the next cycle.
REQ-014 On load_use coinciding with a taken branch, SHALL perform the flush only, with no bubble counted.
REQ-015 SHALL increment each counter by 1 per qualifying cycle or event, and SHALL saturate each counter at all-ones without wrapping.
- stall_cnt_o counts each MEM_STALL freeze cycle.
- flush_cnt_o counts each applied flush.
- bubble_cnt_o counts each load-use bubble.
REQ-016 SHALL have zero-cycle latency from inputs to control outputs; only the state, pend_flush and the counters are registered.

Reset
REQ-017 On rst high at a clk edge, SHALL set state to RUN, pend_flush to 0 and all counters to 0.
REQ-018 During rst, SHALL drive all loads to 1, if_id_flush_o to 0 and controlmux_sel_o to ctrl.
REQ-019 A reset in mid-stall SHALL discard any pending flush.

Structure
REQ-020 SHALL place the state enum hazard_state_t in rv32i_types, and SHALL reuse the controlmux::controlmux_sel_t type.
REQ-021 SHALL implement the three counters as one sub-module, sat_counter, instantiated three times.

Verification
REQ-022 SHALL cover these directed scenarios:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 -> 1 cycle with pc_load=0, if_id_load=0, controlmux_sel=zero; bubble_cnt=1.
- Index x0: ex_rd=0, id_rs1=0, load in EX -> no stall.
- dmem miss: dmem_req=1 with resp low for 4 cycles -> all loads 0 for 4 cycles, loads 1 in the resp cycle; stall_cnt=4.
- Branch during stall: ex_br_taken=1 in stall cycle 2 -> after resp, exactly 1 cycle with if_id_flush=1 and controlmux_sel=zero; flush_cnt=1.
- Branch plus load-use in the same cycle -> flush only, bubble_cnt unchanged.
- Reset mid-stall with pend_flush set -> state RUN and all counters 0 next cycle, with no flush issued.
- Saturation: counter preloaded to 0xFFFFFFFF plus one event -> stays 0xFFFFFFFF.
